wvb_reader_arb: RTL and testbench

- Schedules readout of N per-channel waveform buffers through the single shared rd_ctrl/DPRAM datapath.
- Scans channel not-empty flags round-robin and drives the rd_ctrl req/idx/dpram_mode handshake.
- Latches the returned DPRAM length and hands the filled DPRAM to the host-side reader.
- Sequences multi-DPRAM continuation (rd_ctrl_more) before moving to the next channel.

---
 rtl/wvb_rd_pkg.sv | 23 ++
 rtl/wvb_reader_arb_if.sv | 25 ++
 rtl/rr_arb_sel.sv | 32 +++
 rtl/wvb_reader_arb.sv | 149 ++++++++++++++
 tb/tb_wvb_reader_arb.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wvb_rd_pkg.sv
// Shared types and constants for DPRAM readout clients.
package wvb_rd_pkg;

   localparam int unsigned DPRAM_WORDS = 1024;
   localparam int unsigned LEN_W       = 16;
   localparam int unsigned IDX_W       = 8;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_REQ      = 3'd1,
      S_ACK_DROP = 3'd2,
      S_HOST     = 3'd3,
      S_HOLDOFF  = 3'd4
   } state_e;

   // Index following idx in a ring of n_chan entries.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                input int unsigned n_chan);
      if (32'(idx) + 32'd1 >= n_chan) return '0;
      return idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/wvb_reader_arb_if.sv
// rd_ctrl request/ack handshake plus host-side DPRAM handoff.
interface wvb_reader_arb_if;
   import wvb_rd_pkg::*;

   logic             rd_req;
   logic [IDX_W-1:0] rd_idx;
   logic             rd_dpram_mode;
   logic             rd_ack;
   logic             rd_more;
   logic [LEN_W-1:0] rd_dpram_len;
   logic             dpram_ready;
   logic [LEN_W-1:0] dpram_len;
   logic             dpram_done;

   modport master (
      output rd_req, rd_idx, rd_dpram_mode, dpram_ready, dpram_len,
      input  rd_ack, rd_more, rd_dpram_len, dpram_done
   );

   modport slave (
      input  rd_req, rd_idx, rd_dpram_mode, dpram_ready, dpram_len,
      output rd_ack, rd_more, rd_dpram_len, dpram_done
   );

endinterface

// File: rtl/rr_arb_sel.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arb_sel
   import wvb_rd_pkg::*;
#(
   parameter int unsigned P_N_CHAN = 24
) (
   input  logic [P_N_CHAN-1:0] req,
   input  logic [IDX_W-1:0]    ptr,
   output logic [IDX_W-1:0]    gnt_idx,
   output logic                gnt_valid
);

   // Walk the ring starting at ptr; keep the first hit.
   always_comb begin
      int unsigned c;
      logic [P_N_CHAN-1:0] rot;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      c         = 0;
      rot       = '0;
      for (int unsigned i = 0; i < P_N_CHAN; i++) begin
         c = 32'(ptr) + i;
         if (c >= P_N_CHAN) c = c - P_N_CHAN;
         rot = req >> c;
         if (!gnt_valid && rot[0]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/wvb_reader_arb.sv
// Round-robin scheduler of waveform-buffer readouts through the shared rd_ctrl/DPRAM path.
module wvb_reader_arb
   import wvb_rd_pkg::*;
#(
   parameter int unsigned P_N_CHAN  = 24,
   parameter int unsigned P_HOLDOFF = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [P_N_CHAN-1:0]    chan_mask,
   input  logic                   dpram_mode,
   input  logic [P_N_CHAN-1:0]    wvb_not_empty,
   wvb_reader_arb_if.master       bus,
   output logic                   busy,
   output logic [31:0]            n_evts
);

   localparam int unsigned HO_W = (P_HOLDOFF > 1) ? $clog2(P_HOLDOFF) : 1;

   state_e           state_q, state_d;
   logic             rd_req_q, rd_req_d;
   logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
   logic             mode_q, mode_d;
   logic             ready_q, ready_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             more_q, more_d;
   logic             busy_q, busy_d;
   logic [31:0]      n_evts_q, n_evts_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [HO_W-1:0]  hold_cnt_q, hold_cnt_d;

   logic [P_N_CHAN-1:0] elig_c;
   logic [IDX_W-1:0]    gnt_idx_c;
   logic                gnt_valid_c;

   assign elig_c = wvb_not_empty & chan_mask & {P_N_CHAN{en}};

   rr_arb_sel #(.P_N_CHAN(P_N_CHAN)) u_sel (
      .req       (elig_c),
      .ptr       (rr_ptr_q),
      .gnt_idx   (gnt_idx_c),
      .gnt_valid (gnt_valid_c)
   );

   // Next-state and registered-output logic for the readout sequence.
   always_comb begin
      state_d    = state_q;
      rd_req_d   = rd_req_q;
      rd_idx_d   = rd_idx_q;
      mode_d     = mode_q;
      ready_d    = ready_q;
      len_d      = len_q;
      more_d     = more_q;
      n_evts_d   = n_evts_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_valid_c) begin
               rd_idx_d = gnt_idx_c;
               mode_d   = dpram_mode;
               rd_req_d = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_REQ: begin
            if (bus.rd_ack) begin
               len_d    = bus.rd_dpram_len;
               more_d   = bus.rd_more;
               rd_req_d = 1'b0;
               state_d  = S_ACK_DROP;
            end
         end
         S_ACK_DROP: begin
            if (!bus.rd_ack) begin
               ready_d = 1'b1;
               state_d = S_HOST;
            end
         end
         S_HOST: begin
            if (bus.dpram_done) begin
               ready_d = 1'b0;
               len_d   = '0;
               if (more_q) begin
                  // Continuation keeps the same channel and mode.
                  rd_req_d = 1'b1;
                  state_d  = S_REQ;
               end else begin
                  n_evts_d   = n_evts_q + 32'd1;
                  rr_ptr_d   = rr_next(rd_idx_q, P_N_CHAN);
                  hold_cnt_d = '0;
                  state_d    = S_HOLDOFF;
               end
            end
         end
         S_HOLDOFF: begin
            // Give the not-empty flags time to settle after the buffer was read.
            if (32'(hold_cnt_q) + 32'd1 >= P_HOLDOFF) begin
               state_d = S_IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + HO_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_HOLDOFF);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_req_q   <= 1'b0;
         rd_idx_q   <= '0;
         mode_q     <= 1'b0;
         ready_q    <= 1'b0;
         len_q      <= '0;
         more_q     <= 1'b0;
         busy_q     <= 1'b0;
         n_evts_q   <= '0;
         rr_ptr_q   <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_req_q   <= rd_req_d;
         rd_idx_q   <= rd_idx_d;
         mode_q     <= mode_d;
         ready_q    <= ready_d;
         len_q      <= len_d;
         more_q     <= more_d;
         busy_q     <= busy_d;
         n_evts_q   <= n_evts_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign bus.rd_req        = rd_req_q;
   assign bus.rd_idx        = rd_idx_q;
   assign bus.rd_dpram_mode = mode_q;
   assign bus.dpram_ready   = ready_q;
   assign bus.dpram_len     = len_q;
   assign busy              = busy_q;
   assign n_evts            = n_evts_q;

endmodule

// File: tb/tb_wvb_reader_arb.sv
// Bench for wvb_reader_arb: cycle model of the readout rules plus directed scenarios.
module tb_wvb_reader_arb;
   import wvb_rd_pkg::*;

   localparam int N    = 24;
   localparam int HOLD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [N-1:0]  chan_mask;
   logic          dpram_mode;
   logic [N-1:0]  wvb_not_empty;
   logic          busy;
   logic [31:0]   n_evts;

   wvb_reader_arb_if bus ();

   wvb_reader_arb #(.P_N_CHAN(N), .P_HOLDOFF(HOLD)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .chan_mask     (chan_mask),
      .dpram_mode    (dpram_mode),
      .wvb_not_empty (wvb_not_empty),
      .bus           (bus.master),
      .busy          (busy),
      .n_evts        (n_evts)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // rd_ctrl stand-in: answers each request from a queue of scripted responses.
   typedef struct {
      int          delay;
      logic [15:0] len;
      logic        more;
   } resp_t;
   resp_t resp_q[$];

   task automatic push_resp(input int d, input logic [15:0] l, input logic m);
      resp_t r;
      r.delay = d;
      r.len   = l;
      r.more  = m;
      resp_q.push_back(r);
   endtask

   initial begin
      int wcnt;
      bus.rd_ack       = 1'b0;
      bus.rd_more      = 1'b0;
      bus.rd_dpram_len = '0;
      wcnt             = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.rd_ack = 1'b0;
            wcnt       = 0;
         end else if (bus.rd_ack) begin
            bus.rd_ack = 1'b0;
         end else if (bus.rd_req && resp_q.size() > 0) begin
            if (wcnt >= resp_q[0].delay) begin
               bus.rd_ack       = 1'b1;
               bus.rd_more      = resp_q[0].more;
               bus.rd_dpram_len = resp_q[0].len;
               void'(resp_q.pop_front());
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // Expected outputs, derived from the readout rules as flags and counters.
   logic        e_req, e_acked, e_ready, e_more, e_mode;
   int          e_idx, e_ptr, e_hold;
   logic [15:0] e_len;
   logic [31:0] e_nevts;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++) begin
         int c;
         c = (p + i) % N;
         if (((v >> c) & N'(1)) != '0) return c;
      end
      return -1;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            e_req = 0; e_acked = 0; e_ready = 0; e_more = 0; e_mode = 0;
            e_idx = 0; e_ptr = 0; e_hold = 0; e_len = '0; e_nevts = '0;
         end else if (!(e_req || e_acked || e_ready)) begin
            if (e_hold > 0) begin
               e_hold--;
            end else if (en && (wvb_not_empty & chan_mask) != '0) begin
               e_idx  = pick(wvb_not_empty & chan_mask, e_ptr);
               e_mode = dpram_mode;
               e_req  = 1;
            end
         end else if (e_req) begin
            if (bus.rd_ack) begin
               e_len   = bus.rd_dpram_len;
               e_more  = bus.rd_more;
               e_req   = 0;
               e_acked = 1;
            end
         end else if (e_acked) begin
            if (!bus.rd_ack) begin
               e_acked = 0;
               e_ready = 1;
            end
         end else if (bus.dpram_done) begin
            e_ready = 0;
            e_len   = '0;
            if (e_more) begin
               e_req = 1;
            end else begin
               e_nevts = e_nevts + 32'd1;
               e_ptr   = (e_idx + 1) % N;
               e_hold  = HOLD;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("cyc rd_req",        32'(bus.rd_req),        32'(e_req));
         chk("cyc rd_idx",        32'(bus.rd_idx),        32'(e_idx));
         chk("cyc rd_dpram_mode", 32'(bus.rd_dpram_mode), 32'(e_mode));
         chk("cyc dpram_ready",   32'(bus.dpram_ready),   32'(e_ready));
         chk("cyc dpram_len",     32'(bus.dpram_len),     32'(e_len));
         chk("cyc busy",          32'(busy),              32'(e_req || e_acked || e_ready));
         chk("cyc n_evts",        n_evts,                 e_nevts);
      end
   end

   task automatic wait_ready(input string tag);
      int t;
      t = 0;
      while (!bus.dpram_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " ready timeout"}, 32'(bus.dpram_ready), 32'd1);
   endtask

   task automatic consume();
      bus.dpram_done = 1'b1;
      @(negedge clk);
      bus.dpram_done = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; chan_mask = '0; dpram_mode = 1'b0;
      wvb_not_empty = '0; bus.dpram_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst rd_req", 32'(bus.rd_req), 32'd0);
      chk("rst rd_idx", 32'(bus.rd_idx), 32'd0);
      chk("rst mode",   32'(bus.rd_dpram_mode), 32'd0);
      chk("rst ready",  32'(bus.dpram_ready), 32'd0);
      chk("rst len",    32'(bus.dpram_len), 32'd0);
      chk("rst busy",   32'(busy), 32'd0);
      chk("rst n_evts", n_evts, 32'd0);
      rst_n = 1'b1;

      // Channels 0 and 2 pending: 0 first, then 2.
      en = 1'b1; chan_mask = '1; wvb_not_empty = 24'h000005;
      push_resp(10, 16'h0020, 1'b0);
      push_resp(3, 16'h0011, 1'b0);
      wait_ready("t1a");
      chk("t1a idx", 32'(bus.rd_idx), 32'd0);
      chk("t1a len", 32'(bus.dpram_len), 32'h20);
      consume();
      chk("t1a n_evts", n_evts, 32'd1);
      wait_ready("t1b");
      chk("t1b idx", 32'(bus.rd_idx), 32'd2);
      chk("t1b len", 32'(bus.dpram_len), 32'h11);
      wvb_not_empty = '0;
      consume();
      chk("t1b n_evts", n_evts, 32'd2);
      repeat (8) @(negedge clk);

      // Channel 23, extend mode, one continuation; mode change mid-event ignored.
      dpram_mode = 1'b1; wvb_not_empty = 24'h800000;
      push_resp(2, 16'(2 * DPRAM_WORDS), 1'b1);
      push_resp(4, 16'h0104, 1'b0);
      wait_ready("t2a");
      chk("t2a idx",  32'(bus.rd_idx), 32'd23);
      chk("t2a mode", 32'(bus.rd_dpram_mode), 32'd1);
      chk("t2a len",  32'(bus.dpram_len), 32'd2048);
      wvb_not_empty = '0; dpram_mode = 1'b0;
      consume();
      chk("t2a n_evts", n_evts, 32'd2);
      wait_ready("t2b");
      chk("t2b idx",  32'(bus.rd_idx), 32'd23);
      chk("t2b mode", 32'(bus.rd_dpram_mode), 32'd1);
      chk("t2b len",  32'(bus.dpram_len), 32'h104);
      consume();
      chk("t2b n_evts", n_evts, 32'd3);
      repeat (8) @(negedge clk);

      // Serve 22 to park the pointer at 23, then 23 and 0 pending: 23 then 0.
      wvb_not_empty = 24'h400000;
      push_resp(1, 16'h0022, 1'b0);
      push_resp(1, 16'h0023, 1'b0);
      push_resp(1, 16'h0024, 1'b0);
      wait_ready("t3a");
      chk("t3a idx", 32'(bus.rd_idx), 32'd22);
      wvb_not_empty = 24'h800001;
      consume();
      wait_ready("t3b");
      chk("t3b idx", 32'(bus.rd_idx), 32'd23);
      consume();
      wait_ready("t3c");
      chk("t3c idx wrap", 32'(bus.rd_idx), 32'd0);
      wvb_not_empty = '0;
      consume();
      chk("t3 n_evts", n_evts, 32'd6);
      repeat (8) @(negedge clk);

      // en drops during a multi-DPRAM event: the continuation still finishes.
      wvb_not_empty = 24'h000020;
      push_resp(1, 16'h0400, 1'b1);
      push_resp(2, 16'h0008, 1'b0);
      wait_ready("t4a");
      chk("t4a idx", 32'(bus.rd_idx), 32'd5);
      en = 1'b0;
      consume();
      wait_ready("t4b");
      chk("t4b idx", 32'(bus.rd_idx), 32'd5);
      chk("t4b len", 32'(bus.dpram_len), 32'h8);
      consume();
      chk("t4 n_evts", n_evts, 32'd7);
      repeat (30) @(negedge clk);
      chk("t4 no req en=0",  32'(bus.rd_req), 32'd0);
      chk("t4 no busy en=0", 32'(busy), 32'd0);

      // All channels masked off; a stray dpram_done outside an event is ignored.
      chan_mask = '0; wvb_not_empty = '1; en = 1'b1;
      repeat (5) @(negedge clk);
      consume();
      repeat (25) @(negedge clk);
      chk("t5 masked req",  32'(bus.rd_req), 32'd0);
      chk("t5 masked busy", 32'(busy), 32'd0);
      chk("t5 n_evts",      n_evts, 32'd7);

      // Asynchronous reset while the host holds a DPRAM.
      wvb_not_empty = 24'h000008; chan_mask = '1;
      push_resp(2, 16'h0033, 1'b0);
      wait_ready("t6a");
      chk("t6a idx", 32'(bus.rd_idx), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("t6 rst ready",  32'(bus.dpram_ready), 32'd0);
      chk("t6 rst rd_req", 32'(bus.rd_req), 32'd0);
      chk("t6 rst busy",   32'(busy), 32'd0);
      chk("t6 rst n_evts", n_evts, 32'd0);
      push_resp(1, 16'h0044, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready("t6b");
      chk("t6b idx", 32'(bus.rd_idx), 32'd3);
      chk("t6b len", 32'(bus.dpram_len), 32'h44);
      wvb_not_empty = '0;
      consume();
      chk("t6b n_evts", n_evts, 32'd1);
      repeat (8) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
